// File: rtl/trigger_link_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trigger_link_pkg                                                         |
// | Shared types and constants for the trigger link controller.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package trigger_link_pkg;

  localparam int CLUSTER_W  = 14;
  localparam int N_CLUSTERS = 8;
  localparam int N_LINKS    = 4;
  localparam int LINK_W     = 56;

  localparam logic [LINK_W-1:0] SYNC_WORD = 56'hBC50BC50BC50BC;
  localparam logic [LINK_W-1:0] IDLE_WORD = {4{14'h3FFF}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_SYNC      = 3'd3,
    ST_RUN       = 3'd4
  } tl_state_e;

  // True when every enabled link reports the flag; an empty enable mask never qualifies.
  function automatic logic all_enabled_set(input logic [N_LINKS-1:0] flags,
                                           input logic [N_LINKS-1:0] en);
    return (en != '0) && ((flags & en) == en);
  endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_link_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trigger_link_ctrl_if                                                     |
// | GTX status/control and cluster/link data bundle of the link controller.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface trigger_link_ctrl_if;
  import trigger_link_pkg::*;

  logic [N_LINKS-1:0]              link_en;
  logic [N_LINKS-1:0]              tx_pll_locked;
  logic [N_LINKS-1:0]              tx_reset_done;
  logic [N_CLUSTERS*CLUSTER_W-1:0] clusters;
  logic                            overflow;
  logic                            test_pat_en;
  logic [N_LINKS-1:0]              gtx_reset;
  logic [N_LINKS*LINK_W-1:0]       link_data;
  logic                            link_overflow;
  logic                            link_ready;
  logic [7:0]                      retry_cnt;
  logic [7:0]                      lock_loss_cnt;

  modport master (
    output link_en, tx_pll_locked, tx_reset_done, clusters, overflow, test_pat_en,
    input  gtx_reset, link_data, link_overflow, link_ready, retry_cnt, lock_loss_cnt
  );

  modport slave (
    input  link_en, tx_pll_locked, tx_reset_done, clusters, overflow, test_pat_en,
    output gtx_reset, link_data, link_overflow, link_ready, retry_cnt, lock_loss_cnt
  );

endinterface
`default_nettype wire

// File: rtl/trigger_link_ctrl_prbs7.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trigger_link_prbs7                                                       |
// | PRBS-7 generator (x^7 + x^6 + 1), seeded with 7'h7F.                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module trigger_link_prbs7 (
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_clear,
  input  wire logic       i_adv,
  output logic      [6:0] o_state
);

  logic [6:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_lfsr <= 7'h7F;
    end else if (i_adv) begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    end
  end

  assign o_state = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/trigger_link_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | trigger_link_ctrl                                                        |
// | GTX TX bring-up sequencer and cluster-to-link mapper for 4 trigger links.|
// | Optional PRBS-7 test pattern enabled by macro TRIG_LINK_PRBS_EN.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module trigger_link_ctrl
  import trigger_link_pkg::*;
#(
  parameter int RST_CYCLES   = 16,
  parameter int DONE_TIMEOUT = 1023,
  parameter int SYNC_BX      = 128
) (
  input  wire logic           clk_40,
  input  wire logic           reset,
  trigger_link_ctrl_if.slave  bus
);

  localparam logic [9:0] c_RST_LAST  = 10'(RST_CYCLES - 1);
  localparam logic [9:0] c_DONE_LAST = 10'(DONE_TIMEOUT - 1);
  localparam logic [9:0] c_SYNC_LAST = 10'(SYNC_BX - 1);

  tl_state_e                 r_state;
  tl_state_e                 w_next;
  logic [9:0]                r_cnt;
  logic [N_LINKS-1:0]        r_gtx_reset;
  logic [N_LINKS*LINK_W-1:0] r_link_data;
  logic                      r_link_ovf;
  logic                      r_link_ready;
  logic [7:0]                r_retry_cnt;
  logic [7:0]                r_lock_loss_cnt;

  logic                      w_lock;
  logic                      w_done;
  logic                      w_retry;
  logic                      w_loss_in_run;
  logic                      w_pat;
  logic [LINK_W-1:0]         w_pat_word;
  logic [N_LINKS*LINK_W-1:0] w_run_word;
  logic [N_LINKS*LINK_W-1:0] w_link_next;
  logic                      w_link_ovf;

  assign w_lock = all_enabled_set(bus.tx_pll_locked, bus.link_en);
  assign w_done = all_enabled_set(bus.tx_reset_done, bus.link_en);

  // Lock loss overrides every other transition out of a non-idle state.
  always_comb begin
    w_next        = r_state;
    w_retry       = 1'b0;
    w_loss_in_run = 1'b0;
    if (r_state != ST_IDLE && !w_lock) begin
      w_next        = ST_IDLE;
      w_loss_in_run = (r_state == ST_RUN);
    end else begin
      case (r_state)
        ST_IDLE:      if (w_lock) w_next = ST_RESET;
        ST_RESET:     if (r_cnt == c_RST_LAST) w_next = ST_WAIT_DONE;
        ST_WAIT_DONE: begin
          if (w_done) begin
            w_next = ST_SYNC;
          end else if (r_cnt == c_DONE_LAST) begin
            w_next  = ST_RESET;
            w_retry = 1'b1;
          end
        end
        ST_SYNC:      if (r_cnt == c_SYNC_LAST) w_next = ST_RUN;
        ST_RUN:       w_next = ST_RUN;
        default:      w_next = ST_IDLE;
      endcase
    end
  end

`ifdef TRIG_LINK_PRBS_EN
  logic [6:0] w_prbs;

  // The generator is held at its seed until the pattern starts, so every run begins at 7'h7F.
  assign w_pat      = (w_next == ST_RUN) && bus.test_pat_en;
  assign w_pat_word = {8{w_prbs}};

  trigger_link_prbs7 u_prbs7 (
    .clk     (clk_40),
    .rst     (reset),
    .i_clear (!w_pat),
    .i_adv   (w_pat),
    .o_state (w_prbs)
  );
`else
  logic w_unused_test_pat;

  assign w_unused_test_pat = bus.test_pat_en;
  assign w_pat             = 1'b0;
  assign w_pat_word        = IDLE_WORD;
`endif

  // Links 0/1 carry clusters 0..3, links 2/3 carry clusters 4..7.
  assign w_run_word = {bus.clusters[111:56], bus.clusters[111:56],
                       bus.clusters[55:0],   bus.clusters[55:0]};

  for (genvar gi = 0; gi < N_LINKS; gi++) begin : g_link
    assign w_link_next[gi*LINK_W +: LINK_W] =
      !bus.link_en[gi]   ? IDLE_WORD :
      (w_next == ST_SYNC) ? SYNC_WORD :
      (w_next == ST_RUN)  ? (w_pat ? w_pat_word : w_run_word[gi*LINK_W +: LINK_W]) :
                            IDLE_WORD;
  end

  assign w_link_ovf = (w_next == ST_RUN) && !w_pat && bus.overflow;

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk_40) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_gtx_reset     <= '0;
      r_link_data     <= {N_LINKS{IDLE_WORD}};
      r_link_ovf      <= 1'b0;
      r_link_ready    <= 1'b0;
      r_retry_cnt     <= '0;
      r_lock_loss_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != 10'h3FF) begin
        r_cnt <= r_cnt + 10'd1;
      end
      r_gtx_reset  <= (w_next == ST_RESET) ? bus.link_en : '0;
      r_link_data  <= w_link_next;
      r_link_ovf   <= w_link_ovf;
      r_link_ready <= (w_next == ST_RUN);
      if (w_retry && r_retry_cnt != 8'hFF) begin
        r_retry_cnt <= r_retry_cnt + 8'd1;
      end
      if (w_loss_in_run && r_lock_loss_cnt != 8'hFF) begin
        r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
      end
    end
  end

  assign bus.gtx_reset     = r_gtx_reset;
  assign bus.link_data     = r_link_data;
  assign bus.link_overflow = r_link_ovf;
  assign bus.link_ready    = r_link_ready;
  assign bus.retry_cnt     = r_retry_cnt;
  assign bus.lock_loss_cnt = r_lock_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trigger_link_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_trigger_link_ctrl                                                     |
// | Directed self-checking bench; a second, short-timed instance covers the  |
// | counter saturation paths. PRBS checks apply when TRIG_LINK_PRBS_EN is set.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_trigger_link_ctrl;
  import trigger_link_pkg::*;

  localparam logic [223:0] IDLE4 = {4{IDLE_WORD}};
  localparam logic [223:0] SYNC4 = {4{SYNC_WORD}};

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  trigger_link_ctrl_if if0 ();
  trigger_link_ctrl_if if1 ();

  trigger_link_ctrl u_dut (
    .clk_40 (clk),
    .reset  (rst),
    .bus    (if0)
  );

  trigger_link_ctrl #(.RST_CYCLES(2), .DONE_TIMEOUT(4), .SYNC_BX(3)) u_dut2 (
    .clk_40 (clk),
    .reset  (rst2),
    .bus    (if1)
  );

  always #5 clk = ~clk;

  function automatic logic [223:0] run_exp(input logic [111:0] v, input logic [3:0] en);
    logic [223:0] w;
    w = {v[111:56], v[111:56], v[55:0], v[55:0]};
    for (int i = 0; i < 4; i++) if (!en[i]) w[i*56 +: 56] = IDLE_WORD;
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    if0.link_en = 4'hF; if0.tx_pll_locked = 4'hF; if0.tx_reset_done = 4'h0;
    if0.clusters = '0; if0.overflow = 1'b1; if0.test_pat_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (if0.gtx_reset !== 4'h0) begin failures++; $display("FAIL reset_gtx got=%h exp=0", if0.gtx_reset); end
    checks++; if (if0.link_data !== IDLE4) begin failures++; $display("FAIL reset_data got=%h exp=%h", if0.link_data, IDLE4); end
    checks++; if (if0.link_overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", if0.link_overflow); end
    checks++; if (if0.link_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", if0.link_ready); end
    checks++; if (if0.retry_cnt !== 8'h00) begin failures++; $display("FAIL reset_retry got=%h exp=0", if0.retry_cnt); end
    checks++; if (if0.lock_loss_cnt !== 8'h00) begin failures++; $display("FAIL reset_loss got=%h exp=0", if0.lock_loss_cnt); end
  endtask

  task automatic test_bringup();
    int n;
    n = 0;
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if0.gtx_reset === 4'hF) n++; else if (n > 0) break;
    end
    checks++; if (n != 16) begin failures++; $display("FAIL rst_cycles got=%0d exp=16", n); end
    checks++; if (if0.gtx_reset !== 4'h0) begin failures++; $display("FAIL gtx_after_reset got=%h exp=0", if0.gtx_reset); end
    repeat (4) @(negedge clk);
    checks++; if (if0.link_data !== IDLE4) begin failures++; $display("FAIL wait_done_data got=%h exp=%h", if0.link_data, IDLE4); end
    if0.tx_reset_done = 4'hF;
    @(negedge clk);
    checks++; if (if0.link_data !== SYNC4) begin failures++; $display("FAIL sync_start got=%h exp=%h", if0.link_data, SYNC4); end
    checks++; if (if0.link_ready !== 1'b0) begin failures++; $display("FAIL ready_in_sync got=%b exp=0", if0.link_ready); end
    checks++; if (if0.link_overflow !== 1'b0) begin failures++; $display("FAIL ovf_in_sync got=%b exp=0", if0.link_overflow); end
    n = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if0.link_data === SYNC4) n++; else break;
    end
    checks++; if (n != 128) begin failures++; $display("FAIL sync_len got=%0d exp=128", n); end
    checks++; if (if0.link_ready !== 1'b1) begin failures++; $display("FAIL ready_run got=%b exp=1", if0.link_ready); end
  endtask

  task automatic test_run_data();
    logic [111:0] v [4];
    logic         ov [4];
    logic [55:0]  sl;
    v[0] = '0; v[0][13:0] = 14'h0123; v[0][69:56] = 14'h0456;
    v[1] = 112'h0123456789ABCDEF0123456789AB;
    v[2] = 112'hFEDCBA9876543210FEDCBA987654;
    v[3] = 112'hA5A5A5A5A5A5A5A5A5A5A5A5A5A5;
    ov[0] = 1'b1; ov[1] = 1'b0; ov[2] = 1'b1; ov[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if0.clusters = v[i]; if0.overflow = ov[i];
      @(negedge clk);
      checks++; if (if0.link_data !== run_exp(v[i], 4'hF)) begin failures++; $display("FAIL run_data%0d got=%h exp=%h", i, if0.link_data, run_exp(v[i], 4'hF)); end
      checks++; if (if0.link_overflow !== ov[i]) begin failures++; $display("FAIL run_ovf%0d got=%b exp=%b", i, if0.link_overflow, ov[i]); end
      if (i == 0) begin
        sl = {if0.link_data[181:168], if0.link_data[125:112], if0.link_data[69:56], if0.link_data[13:0]};
        checks++; if (sl !== {14'h0456, 14'h0456, 14'h0123, 14'h0123}) begin failures++; $display("FAIL cluster_slices got=%h exp=%h", sl, {14'h0456, 14'h0456, 14'h0123, 14'h0123}); end
      end
    end
  endtask

`ifndef TRIG_LINK_PRBS_EN
  task automatic test_pat_no_effect();
    logic [111:0] v;
    v = 112'h13579BDF02468ACE13579BDF0246;
    if0.test_pat_en = 1'b1; if0.clusters = v; if0.overflow = 1'b1;
    @(negedge clk);
    checks++; if (if0.link_data !== run_exp(v, 4'hF)) begin failures++; $display("FAIL pat_ignored got=%h exp=%h", if0.link_data, run_exp(v, 4'hF)); end
    checks++; if (if0.link_overflow !== 1'b1) begin failures++; $display("FAIL pat_ignored_ovf got=%b exp=1", if0.link_overflow); end
    if0.test_pat_en = 1'b0;
  endtask
`endif

  task automatic test_lock_loss_run();
    if0.overflow = 1'b1; if0.tx_pll_locked = 4'b1011;
    @(negedge clk);
    checks++; if (if0.link_ready !== 1'b0) begin failures++; $display("FAIL loss_ready got=%b exp=0", if0.link_ready); end
    checks++; if (if0.lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL loss_cnt got=%h exp=01", if0.lock_loss_cnt); end
    checks++; if (if0.link_data !== IDLE4) begin failures++; $display("FAIL loss_data got=%h exp=%h", if0.link_data, IDLE4); end
    checks++; if (if0.link_overflow !== 1'b0) begin failures++; $display("FAIL loss_ovf got=%b exp=0", if0.link_overflow); end
  endtask

  task automatic test_lock_loss_sync();
    bit found;
    found = 0;
    if0.tx_pll_locked = 4'hF;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (if0.link_data === SYNC4) begin found = 1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL resync_reach got=0 exp=1"); end
    if0.tx_pll_locked = 4'b1110;
    @(negedge clk);
    checks++; if (if0.link_data !== IDLE4) begin failures++; $display("FAIL sync_loss_data got=%h exp=%h", if0.link_data, IDLE4); end
    checks++; if (if0.lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL sync_loss_cnt got=%h exp=01", if0.lock_loss_cnt); end
  endtask

  task automatic test_timeout();
    bit found;
    int n;
    if0.tx_reset_done = 4'h0; if0.tx_pll_locked = 4'hF;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (if0.gtx_reset === 4'hF) begin found = 1; break; end
    end
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if0.gtx_reset === 4'h0) begin found = 1; break; end
    end
    n = found ? 1 : 0;
    for (int i = 0; i < 1100 && found; i++) begin
      @(negedge clk);
      if (if0.gtx_reset === 4'h0) n++; else break;
    end
    checks++; if (n != 1023) begin failures++; $display("FAIL timeout_len got=%0d exp=1023", n); end
    checks++; if (if0.gtx_reset !== 4'hF) begin failures++; $display("FAIL retry_reset got=%h exp=f", if0.gtx_reset); end
    checks++; if (if0.retry_cnt !== 8'd1) begin failures++; $display("FAIL retry_cnt got=%h exp=01", if0.retry_cnt); end
  endtask

  task automatic test_partial_links();
    bit found;
    logic [111:0] v;
    rst = 1'b1;
    @(negedge clk);
    if0.link_en = 4'b0011; if0.tx_pll_locked = 4'b0011; if0.tx_reset_done = 4'b0011;
    if0.overflow = 1'b0; rst = 1'b0;
    @(negedge clk);
    checks++; if (if0.gtx_reset !== 4'b0011) begin failures++; $display("FAIL partial_gtx got=%h exp=3", if0.gtx_reset); end
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if0.link_data === {IDLE_WORD, IDLE_WORD, SYNC_WORD, SYNC_WORD}) begin found = 1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL partial_sync got=%h exp=%h", if0.link_data, {IDLE_WORD, IDLE_WORD, SYNC_WORD, SYNC_WORD}); end
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if0.link_ready === 1'b1) begin found = 1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL partial_ready got=0 exp=1"); end
    v = 112'h0123456789ABCDEF0123456789AB;
    if0.clusters = v;
    @(negedge clk);
    checks++; if (if0.link_data !== run_exp(v, 4'b0011)) begin failures++; $display("FAIL partial_data got=%h exp=%h", if0.link_data, run_exp(v, 4'b0011)); end
  endtask

  task automatic test_en_change();
    if0.link_en = 4'b0111;
    @(negedge clk);
    checks++; if (if0.link_ready !== 1'b0) begin failures++; $display("FAIL en_change_ready got=%b exp=0", if0.link_ready); end
    checks++; if (if0.lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL en_change_loss got=%h exp=01", if0.lock_loss_cnt); end
    if0.link_en = 4'h0; if0.tx_pll_locked = 4'hF;
    repeat (20) @(negedge clk);
    checks++; if (if0.gtx_reset !== 4'h0 || if0.link_ready !== 1'b0) begin failures++; $display("FAIL en_zero got=%h/%b exp=0/0", if0.gtx_reset, if0.link_ready); end
  endtask

  task automatic test_reset_mid_sync();
    bit found;
    if0.link_en = 4'hF; if0.tx_pll_locked = 4'hF; if0.tx_reset_done = 4'hF; if0.overflow = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if0.link_data === SYNC4) begin found = 1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL mid_sync_reach got=0 exp=1"); end
    checks++; if (if0.lock_loss_cnt !== 8'd1) begin failures++; $display("FAIL pre_reset_loss got=%h exp=01", if0.lock_loss_cnt); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (if0.link_data !== IDLE4) begin failures++; $display("FAIL mid_reset_data got=%h exp=%h", if0.link_data, IDLE4); end
    checks++; if (if0.lock_loss_cnt !== 8'd0) begin failures++; $display("FAIL mid_reset_loss got=%h exp=0", if0.lock_loss_cnt); end
    checks++; if (if0.gtx_reset !== 4'h0 || if0.link_ready !== 1'b0 || if0.link_overflow !== 1'b0) begin failures++; $display("FAIL mid_reset_ctl got=%h/%b/%b exp=0/0/0", if0.gtx_reset, if0.link_ready, if0.link_overflow); end
    @(negedge clk);
    checks++; if (if0.link_data !== IDLE4) begin failures++; $display("FAIL mid_reset_hold got=%h exp=%h", if0.link_data, IDLE4); end
    rst = 1'b0;
  endtask

`ifdef TRIG_LINK_PRBS_EN
  task automatic test_prbs();
    bit found;
    logic [6:0] m;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if0.link_ready === 1'b1) begin found = 1; break; end
    end
    checks++; if (!found) begin failures++; $display("FAIL prbs_ready got=0 exp=1"); end
    if0.test_pat_en = 1'b1; if0.overflow = 1'b1;
    m = 7'h7F;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      checks++; if (if0.link_data !== {32{m}} || if0.link_overflow !== 1'b0) begin failures++; $display("FAIL prbs%0d got=%h exp=%h", i, if0.link_data, {32{m}}); end
      m = {m[5:0], m[6] ^ m[5]};
    end
    if0.test_pat_en = 1'b0;
  endtask
`endif

  task automatic test_retry_sat();
    logic [3:0] prev;
    int rises;
    prev = 4'h0; rises = 0;
    rst2 = 1'b0;
    for (int i = 0; i < 3000 && rises < 301; i++) begin
      @(negedge clk);
      if (if1.gtx_reset !== 4'h0 && prev === 4'h0) begin
        rises++;
        if (rises == 101) begin
          checks++; if (if1.retry_cnt !== 8'd100) begin failures++; $display("FAIL retry_mid got=%0d exp=100", if1.retry_cnt); end
        end
      end
      prev = if1.gtx_reset;
    end
    checks++; if (rises != 301) begin failures++; $display("FAIL retry_rises got=%0d exp=301", rises); end
    checks++; if (if1.retry_cnt !== 8'hFF) begin failures++; $display("FAIL retry_sat got=%h exp=ff", if1.retry_cnt); end
  endtask

  task automatic test_lock_loss_sat();
    bit found;
    rst2 = 1'b1;
    @(negedge clk);
    if1.tx_reset_done = 4'hF; rst2 = 1'b0;
    for (int k = 1; k <= 260; k++) begin
      found = 0;
      for (int j = 0; j < 30; j++) begin
        @(negedge clk);
        if (if1.link_ready === 1'b1) begin found = 1; break; end
      end
      if (!found) begin
        checks++; failures++; $display("FAIL loss_sat_ready got=0 exp=1 iter=%0d", k);
        break;
      end
      if1.tx_pll_locked = 4'h0;
      @(negedge clk);
      if1.tx_pll_locked = 4'hF;
      if (k == 10) begin
        checks++; if (if1.lock_loss_cnt !== 8'd10) begin failures++; $display("FAIL loss_mid got=%0d exp=10", if1.lock_loss_cnt); end
      end
    end
    checks++; if (if1.lock_loss_cnt !== 8'hFF) begin failures++; $display("FAIL loss_sat got=%h exp=ff", if1.lock_loss_cnt); end
    checks++; if (if1.retry_cnt !== 8'h00) begin failures++; $display("FAIL loss_sat_retry got=%h exp=0", if1.retry_cnt); end
  endtask

  initial begin
    if1.link_en = 4'hF; if1.tx_pll_locked = 4'hF; if1.tx_reset_done = 4'h0;
    if1.clusters = '0; if1.overflow = 1'b0; if1.test_pat_en = 1'b0;
    test_reset();
    test_bringup();
    test_run_data();
`ifndef TRIG_LINK_PRBS_EN
    test_pat_no_effect();
`endif
    test_lock_loss_run();
    test_lock_loss_sync();
    test_timeout();
    test_partial_links();
    test_en_change();
    test_reset_mid_sync();
`ifdef TRIG_LINK_PRBS_EN
    test_prbs();
`endif
    test_retry_sat();
    test_lock_loss_sat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
